// File: rtl/serializador_pkg.sv
// Shared definitions for the word serializer: FSM encoding and default geometry.
package serializador_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2
  } state_e;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefGap   = 0;

  // GAP is limited to 0..7, so three bits always cover the gap count.
  localparam int unsigned GapCntW = 3;

  // Bits needed to hold WIDTH-1 in the bit counter (WIDTH >= 2).
  function automatic int unsigned bit_cnt_width(int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serializador_if.sv
// Parallel-in / serial-out bundle between the upstream producer, the serializer and the detector.
interface serializador_if
  import serializador_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
);

  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             x;
  logic             x_valid;
  logic             last;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  x,
    input  x_valid,
    input  last
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output x,
    output x_valid,
    output last
  );

endinterface

// File: rtl/serializador_contador_bits.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module serializador_contador_bits #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/serializador.sv
// MSB-first word serializer with valid/ready intake and an optional idle gap between words.
module serializador
  import serializador_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned GAP   = DefGap
) (
  input logic           clk,
  input logic           rst,
  serializador_if.slave bus
);

  localparam int unsigned BitCntW = bit_cnt_width(WIDTH);
  localparam logic [BitCntW-1:0] BitLoad = BitCntW'(WIDTH - 1);
  localparam logic [GapCntW-1:0] GapLoad = GapCntW'((GAP == 0) ? 0 : GAP - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;

  logic bit_load, bit_dec, bit_zero;
  logic gap_load, gap_dec, gap_zero;

  serializador_contador_bits #(
    .CW(BitCntW)
  ) u_bit_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (bit_load),
    .load_value(BitLoad),
    .dec       (bit_dec),
    .zero      (bit_zero)
  );

  serializador_contador_bits #(
    .CW(GapCntW)
  ) u_gap_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (gap_load),
    .load_value(GapLoad),
    .dec       (gap_dec),
    .zero      (gap_zero)
  );

  // Outputs depend only on state_q/sr_q/counter flags, never on data_in or valid_in.
  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bit_load      = 1'b0;
    bit_dec       = 1'b0;
    gap_load      = 1'b0;
    gap_dec       = 1'b0;
    bus.ready_out = 1'b0;
    bus.x         = 1'b0;
    bus.x_valid   = 1'b0;
    bus.last      = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.ready_out = 1'b1;
        if (bus.valid_in) begin
          sr_d     = bus.data_in;
          bit_load = 1'b1;
          state_d  = StShift;
        end
      end

      StShift: begin
        bus.x       = sr_q[WIDTH-1];
        bus.x_valid = 1'b1;
        sr_d        = {sr_q[WIDTH-2:0], 1'b0};
        if (bit_zero) begin
          bus.last = 1'b1;
          if (GAP == 0) begin
            // Back-to-back: a word taken on the LSB cycle follows with no bubble.
            bus.ready_out = 1'b1;
            if (bus.valid_in) begin
              sr_d     = bus.data_in;
              bit_load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            gap_load = 1'b1;
            state_d  = StGap;
          end
        end else begin
          bit_dec = 1'b1;
        end
      end

      StGap: begin
        if (gap_zero) begin
          state_d = StIdle;
        end else begin
          gap_dec = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
    end
  end

endmodule
